// File: rtl/tone_pkg.sv
// Shared types and tables for the tone sequencer: note prescales (25 MHz),
// per-channel pitch/duration tables and the player state encoding.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_e;

  localparam logic [9:0] NOTE_DO = 10'h175;
  localparam logic [9:0] NOTE_RE = 10'h14C;
  localparam logic [9:0] NOTE_MI = 10'h128;
  localparam logic [9:0] NOTE_FA = 10'h117;
  localparam logic [9:0] NOTE_LA = 10'h0DD;
  localparam logic [9:0] NOTE_SI = 10'h18B;

  // Tables are sized for up to 8 channels; entries 6 and 7 repeat 0 and 1.
  localparam int MAX_CH = 8;

  localparam logic [9:0] PITCH [MAX_CH] = '{
    NOTE_DO, NOTE_RE, NOTE_MI, NOTE_FA, NOTE_LA, NOTE_SI, NOTE_DO, NOTE_RE
  };

  localparam logic [7:0] DUR [MAX_CH] = '{
    8'd3, 8'd4, 8'd10, 8'd5, 8'd2, 8'd6, 8'd3, 8'd4
  };

endpackage

// File: rtl/tone_fifo.sv
// Synchronous tone-request FIFO holding channel indices; a separate count
// register disambiguates full from empty when the pointers coincide.
module tone_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/tone_sequencer.sv
// Priority tone sequencer: request edges are latched as pending, queued in
// priority order, then played one tone at a time with optional preemption.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int DEPTH      = 4,
  parameter int PS_W       = 10,
  parameter int DUR_W      = 6,
  parameter int GAP_FRAMES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      startOfFrame,
  input  logic [NUM_CH-1:0]         request,
  input  logic                      preempt,
  output logic [PS_W-1:0]           preScaleValue,
  output logic                      busy,
  output logic [$clog2(NUM_CH)-1:0] activeChannel,
  output logic                      dropPulse
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int GAP_W = $clog2(GAP_FRAMES + 2);
  localparam logic [DUR_W-1:0] DUR_ONE  = 1;
  localparam logic [GAP_W-1:0] GAP_ONE  = 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_FRAMES);

  logic [NUM_CH-1:0] hist_q, armed_q, pending_q, pending_d, req_edge, push_mask;
  logic              drop_q, push_vld;
  logic [CH_W-1:0]   push_ch, fifo_head, ac_q;
  logic              fifo_full, fifo_empty, pop_w, preempt_hit;
  state_e            state_q;
  logic [PS_W-1:0]   ps_q, load_ps;
  logic [DUR_W-1:0]  dur_q, load_dur;
  logic [GAP_W-1:0]  gap_q;
  logic [2:0]        tbl_idx;

  // A channel held high through reset is disarmed until it drops to 0.
  assign req_edge = request & ~hist_q & armed_q;

  always_comb begin
    push_vld = 1'b0;
    push_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_vld = 1'b1;
        push_ch  = CH_W'(i);
      end
    end
    push_mask = (push_vld && !fifo_full) ? (NUM_CH'(1) << push_ch) : '0;
    pending_d = (pending_q & ~push_mask) | (req_edge & ~pending_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q    <= '0;
      armed_q   <= ~request;
      pending_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      hist_q    <= request;
      armed_q   <= armed_q | ~request;
      pending_q <= pending_d;
      drop_q    <= |(req_edge & pending_q);
    end
  end

  tone_fifo #(
    .DEPTH (DEPTH),
    .W     (CH_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_vld && !fifo_full),
    .wdata (push_ch),
    .pop   (pop_w),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign preempt_hit = (state_q == ST_PLAY) && preempt && !fifo_empty && (fifo_head < ac_q);
  assign pop_w       = ((state_q == ST_IDLE) && !fifo_empty) || preempt_hit;
  assign tbl_idx     = 3'(fifo_head);
  assign load_ps     = PS_W'(PITCH[tbl_idx]);
  assign load_dur    = DUR_W'(DUR[tbl_idx]);

  // A frame tick on the load cycle is not counted against the new tone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ps_q    <= '0;
      ac_q    <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_w) begin
            state_q <= ST_PLAY;
            ps_q    <= load_ps;
            ac_q    <= fifo_head;
            dur_q   <= load_dur;
          end
        end
        ST_PLAY: begin
          if (preempt_hit) begin
            ps_q  <= load_ps;
            ac_q  <= fifo_head;
            dur_q <= load_dur;
          end else if (startOfFrame) begin
            if (dur_q == DUR_ONE) begin
              ps_q  <= '0;
              ac_q  <= '0;
              dur_q <= '0;
              if (GAP_FRAMES == 0) begin
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_GAP;
                gap_q   <= GAP_LOAD;
              end
            end else begin
              dur_q <= dur_q - DUR_ONE;
            end
          end
        end
        ST_GAP: begin
          if (startOfFrame) begin
            if (gap_q == GAP_ONE) begin
              state_q <= ST_IDLE;
              gap_q   <= '0;
            end else begin
              gap_q <= gap_q - GAP_ONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign preScaleValue = ps_q;
  assign activeChannel = ac_q;
  assign busy          = (state_q != ST_IDLE) || !fifo_empty;
  assign dropPulse     = drop_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: a queue-based reference model predicts
// each tone (channel, start cycle, frames) and each drop; a monitor compares.
module tb_tone_sequencer;

  localparam int NUM_CH     = 6;
  localparam int DEPTH      = 4;
  localparam int PS_W       = 10;
  localparam int DUR_W      = 6;
  localparam int GAP_FRAMES = 1;
  localparam int CH_W       = 3;

  logic              clk = 1'b0;
  logic              reset, startOfFrame, preempt;
  logic [NUM_CH-1:0] request;
  logic [PS_W-1:0]   preScaleValue;
  logic              busy, dropPulse;
  logic [CH_W-1:0]   activeChannel;

  always #5 clk = ~clk;

  tone_sequencer #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .PS_W(PS_W), .DUR_W(DUR_W), .GAP_FRAMES(GAP_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .request(request),
    .preempt(preempt), .preScaleValue(preScaleValue), .busy(busy),
    .activeChannel(activeChannel), .dropPulse(dropPulse)
  );

  int ref_pitch [NUM_CH] = '{'h175, 'h14C, 'h128, 'h117, 'h0DD, 'h18B};
  int ref_dur   [NUM_CH] = '{3, 4, 10, 5, 2, 6};

  typedef struct {
    int ch;
    int start;
    int frames;
  } tone_t;

  tone_t exp_q[$];
  int    drop_q[$];
  int    checks = 0, errors = 0, cyc = 0, tones_seen = 0;
  bit    mon_en = 1'b0;

  // Reference model state
  bit m_prev [NUM_CH];
  bit m_armed[NUM_CH];
  bit m_pend [NUM_CH];
  int m_fifo[$];
  int m_cur = -1, m_left = 0, m_frames = 0, m_start = 0, m_gap = 0;
  bit m_busy = 1'b0;

  task automatic m_end();
    tone_t t;
    t.ch = m_cur; t.start = m_start; t.frames = m_frames;
    exp_q.push_back(t);
    m_cur = -1;
  endtask

  task automatic m_load(input int ch);
    m_cur = ch; m_left = ref_dur[ch]; m_frames = 0; m_start = cyc;
  endtask

  function automatic bit model_quiet();
    bit q;
    q = (m_cur < 0) && (m_gap == 0) && (m_fifo.size() == 0);
    for (int i = 0; i < NUM_CH; i++) if (m_pend[i]) q = 1'b0;
    return q;
  endfunction

  always @(posedge clk) begin
    int fsize, pch;
    bit dropped;
    bit newp[NUM_CH];
    cyc++;
    if (reset) begin
      if (m_cur >= 0) begin
        if (startOfFrame) m_frames++;
        m_end();
      end
      m_fifo.delete();
      m_gap = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_pend[i] = 1'b0; m_prev[i] = 1'b0; m_armed[i] = !request[i];
      end
    end else begin
      fsize = m_fifo.size();
      if (m_cur >= 0) begin
        if (startOfFrame) m_frames++;
        if (preempt && m_fifo.size() > 0 && m_fifo[0] < m_cur) begin
          m_end();
          m_load(m_fifo.pop_front());
        end else if (startOfFrame) begin
          m_left--;
          if (m_left == 0) begin
            m_end();
            m_gap = GAP_FRAMES;
          end
        end
      end else if (m_gap > 0) begin
        if (startOfFrame) m_gap--;
      end else if (m_fifo.size() > 0) begin
        m_load(m_fifo.pop_front());
      end
      dropped = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        newp[i] = 1'b0;
        if (request[i] && !m_prev[i] && m_armed[i]) begin
          if (m_pend[i]) dropped = 1'b1;
          else newp[i] = 1'b1;
        end
      end
      if (dropped) drop_q.push_back(cyc);
      pch = -1;
      for (int i = NUM_CH - 1; i >= 0; i--) if (m_pend[i]) pch = i;
      if (pch >= 0 && fsize < DEPTH) begin
        m_fifo.push_back(pch);
        m_pend[pch] = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (newp[i]) m_pend[i] = 1'b1;
        m_prev[i] = request[i];
        if (!request[i]) m_armed[i] = 1'b1;
      end
    end
    m_busy = (m_cur >= 0) || (m_gap > 0) || (m_fifo.size() > 0);
  end

  // Monitor: a tone segment is a run of cycles with one nonzero (pitch, channel)
  bit              seg_on = 1'b0;
  logic [PS_W-1:0] seg_ps;
  logic [CH_W-1:0] seg_ch;
  int              seg_start, seg_frames;

  task automatic close_seg();
    tone_t t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL tone_unexpected: got ch=%0d ps=%h start=%0d frames=%0d, none expected",
               seg_ch, seg_ps, seg_start, seg_frames);
    end else begin
      t = exp_q.pop_front();
      if (int'(seg_ch) != t.ch || int'(seg_ps) != ref_pitch[t.ch] ||
          seg_start != t.start || seg_frames != t.frames) begin
        errors++;
        $display("FAIL tone: got ch=%0d ps=%h start=%0d frames=%0d, expected ch=%0d ps=%h start=%0d frames=%0d",
                 seg_ch, seg_ps, seg_start, seg_frames, t.ch, ref_pitch[t.ch], t.start, t.frames);
      end
    end
    seg_on = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy !== m_busy) begin
        errors++;
        $display("FAIL busy @%0d: got %b expected %b", cyc, busy, m_busy);
      end
      if (dropPulse === 1'b1) begin
        checks++;
        if (drop_q.size() == 0) begin
          errors++;
          $display("FAIL drop_unexpected @%0d", cyc);
        end else if (drop_q[0] != cyc) begin
          errors++;
          $display("FAIL drop_cycle: got %0d expected %0d", cyc, drop_q[0]);
          void'(drop_q.pop_front());
        end else begin
          void'(drop_q.pop_front());
        end
      end
      if (preScaleValue !== '0) begin
        if (!seg_on || preScaleValue !== seg_ps || activeChannel !== seg_ch) begin
          if (seg_on) close_seg();
          seg_on = 1'b1; seg_ps = preScaleValue; seg_ch = activeChannel;
          seg_start = cyc; seg_frames = 0;
          tones_seen++;
        end
        if (startOfFrame) seg_frames++;
      end else begin
        if (seg_on) close_seg();
        checks++;
        if (activeChannel !== '0) begin
          errors++;
          $display("FAIL idle_channel @%0d: got %0d expected 0", cyc, activeChannel);
        end
      end
    end
  end

  // Frame ticks at random intervals
  initial begin
    startOfFrame = 1'b0;
    forever begin
      @(posedge clk); #1;
      startOfFrame = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] mask);
    request = request | mask; step(2);
    request = request & ~mask; step(1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((!model_quiet() || busy !== 1'b0) && n < budget) begin step(); n++; end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
    step(3);
  endtask

  initial begin
    int t0;
    reset = 1'b1; request = '0; preempt = 1'b0;
    @(posedge clk); #1; mon_en = 1'b1;
    @(negedge clk);
    chk("reset_ps", preScaleValue, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ch", activeChannel, 0);
    chk("reset_drop", dropPulse, 0);
    step(2); reset = 1'b0; step(2);

    // Single ch2 tone with exact load latency
    request[2] = 1'b1;
    @(posedge clk);
    @(posedge clk); @(negedge clk);
    chk("lat_e1_ps", preScaleValue, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_e2_ps", preScaleValue, 'h128);
    chk("lat_e2_ch", activeChannel, 2);
    @(posedge clk); #1 request[2] = 1'b0;
    wait_idle(400);

    // Simultaneous ch4 and ch1
    pulse(6'b010010);
    wait_idle(400);

    // Queue fills while ch5 plays; then a repeat edge on a held pending channel
    pulse(6'b100000); step(3);
    pulse(6'b010111); step(6);
    pulse(6'b001000);
    pulse(6'b001000);
    wait_idle(1500);

    // Preemption of ch5 by ch0
    preempt = 1'b1;
    pulse(6'b100000); step(4);
    request[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); @(negedge clk);
    chk("preempt_ps", preScaleValue, 'h175);
    chk("preempt_ch", activeChannel, 0);
    @(posedge clk); #1 request[0] = 1'b0;
    wait_idle(600);
    preempt = 1'b0;

    // Reset mid-tone with three queued, ch3 held through reset
    pulse(6'b100000); step(3);
    request = request | 6'b001110; step(2);
    request = request & ~6'b000110; step(3);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midreset_ps", preScaleValue, 0);
    chk("midreset_busy", busy, 0);
    reset = 1'b0;
    step(20);
    chk("held_no_retrigger_busy", busy, 0);
    request[3] = 1'b0;
    wait_idle(400);

    // Long-held request plays once
    t0 = tones_seen;
    request[1] = 1'b1; step(100);
    request[1] = 1'b0;
    wait_idle(400);
    chk("held_one_tone", tones_seen - t0, 1);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 9) == 0) request[i] = ~request[i];
      preempt = ($urandom_range(0, 2) == 0);
      step();
    end
    request = '0; preempt = 1'b0;
    wait_idle(4000);

    chk("tones_outstanding", exp_q.size(), 0);
    chk("drops_outstanding", drop_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter NUM_CH, default 6, number of independent audio request channels; channel 0 has the highest priority.
REQ-002 Parameter DEPTH, default 4, tone queue depth in entries, power of two, at least 2.
REQ-003 Parameter PS_W, default 10, width of the prescale output.
REQ-004 Parameter DUR_W, default 6, width of the per-tone duration counter in frames.
REQ-005 Parameter GAP_FRAMES, default 1, silent frames inserted between consecutive tones; 0 allowed.
REQ-006 clk  input  1  system clock; the block has one clock; all logic is on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 startOfFrame  input  1  one-cycle frame tick.
REQ-009 request  input  NUM_CH  level audio requests, one bit per channel.
REQ-010 preempt  input  1  1 = a higher-priority queued tone aborts the tone that is playing.
REQ-011 preScaleValue  output  PS_W  tone generator prescale; 0 = silence.
REQ-012 busy  output  1  high while in PLAY or GAP, or while the queue is non-empty.
REQ-013 activeChannel  output  $clog2(NUM_CH)  channel currently playing; 0 when silent.
REQ-014 dropPulse  output  1  one-cycle pulse when a request is discarded.

Function
REQ-015 A request is a rising edge only: sampled 1 with the previous sample 0. A held level never re-triggers.
REQ-016 Edge at clock edge E sets pending[i] at E.
REQ-017 At E+1, the lowest-index set pending bit is pushed into the FIFO and cleared, if the FIFO is not full. One push per cycle at most.
REQ-018 If pending[i] is already set when a new edge on channel i arrives, the new edge is dropped and dropPulse is asserted for one cycle.
REQ-019 While the FIFO is full, pending bits hold; nothing is lost at that stage.
REQ-020 FSM states:
- IDLE: if the FIFO is non-empty, pop the head, load preScaleValue = PITCH[ch] and the duration counter = DUR[ch], then go to PLAY.
- PLAY: on each startOfFrame, decrement the duration counter. On the startOfFrame where the counter is 1, go to GAP, or to IDLE if GAP_FRAMES = 0.
- GAP: preScaleValue = 0. Count GAP_FRAMES startOfFrame ticks, then go to IDLE.
REQ-021 Minimum latency: an edge at E gives preScaleValue valid after E+2, in PLAY.
REQ-022 A tone lasts exactly DUR[ch] startOfFrame ticks. Table DUR values are at least 1.
REQ-023 startOfFrame coincident with a load cycle is ignored for the newly loaded tone.
REQ-024 Preempt: with preempt = 1 in PLAY and the FIFO head channel lower-index than activeChannel, pop and load the head in that cycle with no gap.
REQ-025 With preempt = 0, or an equal/higher head index, the playing tone completes normally.
REQ-026 Outside PLAY, preScaleValue = 0 and activeChannel = 0.
REQ-027 FIFO pointers wrap modulo DEPTH. A full-and-empty ambiguity is resolved with a count register of width $clog2(DEPTH)+1.

Reset
REQ-028 On reset = 1 at a clock edge, the following are cleared at that edge: state = IDLE, preScaleValue = 0, activeChannel = 0, busy = 0, dropPulse = 0, pending = 0, FIFO empty, counters = 0, edge-detect history = 0.
REQ-029 A reset asserted mid-tone silences the output on the same edge, and queued tones are discarded.
REQ-030 After reset, an input already held high is not an edge until it returns to 0.

Structure
REQ-031 Package tone_pkg holds:
- note prescale constants for 25 MHz (do 10'h175, re 10'h14C, mi 10'h128, fa 10'h117, La 10'h0DD, si 10'h18B);
- the PITCH and DUR tables indexed by channel;
- the FSM state enum.
REQ-032 Sub-module tone_fifo (DEPTH × $clog2(NUM_CH), synchronous, with full/empty outputs) is instantiated once.

Verification
REQ-033 Single edge on ch2 (PITCH mi, DUR 10), GAP_FRAMES 1 -> preScaleValue 10'h128 from E+2 for 10 SOF, 0 for 1 SOF, then busy = 0.
REQ-034 Simultaneous edges on ch4 and ch1 -> ch1 tone plays first, then gap, then ch4.
REQ-035 Five edges on distinct channels while ch5 plays, DEPTH 4 -> all play in priority/arrival order and no dropPulse. A repeat ch3 edge while pending[3] is set -> dropPulse = 1 for one cycle.
REQ-036 ch5 playing, preempt = 1, edge on ch0 -> preScaleValue switches to PITCH[0] at E+2 and activeChannel = 0.
REQ-037 reset pulsed mid-PLAY with 3 entries queued -> preScaleValue = 0 on the next edge; the held request does not retrigger.
REQ-038 request held high for 100 cycles -> exactly one tone played.
